instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that produces the instruction stream consumed by the main opcode decoder. Holds the program counter, issues word requests to instruction memory over a valid/ready request channel, buffers returned instructions in a small in-order queue, and presents one instruction (with its PC and opcode field) per handshake to decode. Branch/jump resolution redirects the PC and flushes all stale fetches.

## Interface
Parameters:
- XLEN, 64, PC/address width
- RESET_PC, 64'h0, PC loaded on reset
- DEPTH, 2, instruction buffer entries; also the cap on outstanding + buffered fetches (power of two, ≥2)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  XLEN  word-aligned fetch address
- imem_rsp_valid  input  1  response valid, in order, ≥1 cycle after request accept
- imem_rsp_data  input  32  instruction word
- if_valid  output  1  instruction available to decode
- if_ready  input  1  decode accepts instruction
- if_instr  output  32  instruction word
- if_opcode  output  7  if_instr[6:0]
- if_pc  output  XLEN  PC of if_instr
- redirect_valid  input  1  taken branch/jump or restart
- redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored (forced 0)
- halted  output  1  fetch stopped on SYSTEM instruction (see Configuration)

## Operation
- State machine: RESET → RUN → (HALT, macro only). RESET held while rst; first cycle after rst deasserts is RUN.
- Request issue (RUN): imem_req_valid = (outstanding + count < DEPTH) && !redirect_valid && drop_cnt == 0 is not required (drops may overlap new requests). imem_addr = pc. On req handshake: pc ← pc + 4, outstanding++.
- Response: outstanding--. If drop_cnt > 0: discard, drop_cnt--. Else write {pc_tag, data} into buffer tail; pc_tag comes from a parallel in-order tag queue of issued addresses.
- Credit rule guarantees buffer never overflows; imem_rsp_valid is never back-pressured.
- Output: if_valid = count > 0; if_instr/if_pc/if_opcode from head entry. Pop on if_valid && if_ready.
- Redirect (any state, highest priority): pc ← {redirect_pc[XLEN-1:2],2'b00}; buffer and tag queue cleared; drop_cnt ← outstanding after this cycle's response accounting; no request and no pop that cycle; HALT → RUN.
- Simultaneous push and pop: count unchanged. Simultaneous response and redirect: response counted, then dropped by drop_cnt arithmetic (i.e. not written).
- PC arithmetic is modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.

## Timing
- Reset values: imem_req_valid 0, imem_addr RESET_PC, if_valid 0, if_instr 0, if_opcode 0, if_pc 0, halted 0; pc = RESET_PC, count/outstanding/drop_cnt = 0.
- First request: cycle 1 after rst deasserts.
- Latency: response at cycle N → if_valid at N+1 (no bypass). Redirect at cycle R → first request to new PC at R+1.
- Steady state with 1-cycle memory and if_ready high: one instruction per cycle.
- if_valid, if_instr, if_pc stable while if_valid && !if_ready (except on redirect, which clears them next cycle).

## Configuration
- IFU_HALT_ON_SYSTEM_EN defined: when an instruction with opcode 7'b1110011 is accepted by decode, next cycle enters HALT: halted=1, buffer cleared, outstanding responses dropped, no requests; only redirect_valid (or rst) leaves HALT.
- Undefined: SYSTEM instructions flow like any other; halted tied 0; no HALT state.

## Structure
- Shared package: opcode constants (OP_SYSTEM 7'b1110011 and the other RV opcodes used by the decoder), fetch state enum, XLEN default.
- One sub-module: ifu_fifo (parameterised DEPTH synchronous FIFO with clear, push, pop, count), instantiated for the instruction buffer; the tag queue may reuse it.

## Test plan
- Reset then 1-cycle memory, if_ready=1 → requests at 0x0,0x4,0x8…; if_pc 0x0 at cycle 3, then one per cycle.
- if_ready=0 for 5 cycles → exactly DEPTH (2) fetched-but-unconsumed; no third request; if_pc 0x0 held stable.
- 3-cycle memory, redirect_pc=0x103 with 2 in flight → both stale responses dropped; next if_pc = 0x100.
- Redirect in same cycle as response and pop → buffer empty next cycle, no stale instruction emitted.
- Macro on: accept 32'h00000073 at pc 0x8 → halted=1, no requests; redirect to 0x40 → halted=0, fetch 0x40. Macro off: 0x73 passes, 0xC fetched.
- rst asserted mid-stream with 2 outstanding → all outputs reset values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch stage and its decoder
// neighbour: default address width, RV32/RV64 major opcode constants and the
// fetch state machine encoding.
// Optional feature macro used by importers: IFU_HALT_ON_SYSTEM_EN
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Major opcodes (instr[6:0]) recognised by the downstream decoder
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_system(input logic [31:0] instr);
    return instr[6:0] == OP_SYSTEM;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Small synchronous FIFO used for the fetch instruction buffer and for the
// in-order tag queue of issued fetch addresses.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         empties the FIFO (wins over a same-cycle push)
//   push, din     write one entry (ignored when full and not popping)
//   pop           remove head entry (ignored when empty)
//   dout          head entry (undefined while empty)
//   count         number of valid entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping. A clear behaves like a reset so a
  // flush in the same cycle as a push leaves the FIFO empty.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; readers only look at dout while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: holds the PC, issues word fetches over a valid/ready request
// channel, buffers in-order responses with their PCs and hands one
// instruction per handshake to decode. A redirect reloads the PC and throws
// away everything fetched or in flight for the old path.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  fetch request channel
//   imem_rsp_valid, imem_rsp_data    in-order responses, never back-pressured
//   if_valid/ready, if_instr, if_opcode, if_pc   decode handshake
//   redirect_valid, redirect_pc      branch/jump/restart target
//   halted                           fetch stopped on a SYSTEM instruction
// Optional feature: define IFU_HALT_ON_SYSTEM_EN to stop fetching after decode
// accepts a SYSTEM instruction; otherwise halted is always 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode,
  output logic [XLEN-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;
  localparam int BW = XLEN + 32;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   tag_count;
  logic [BW-1:0]   buf_dout;
  logic [XLEN-1:0] tag_dout;
  logic [SW-1:0]   outstanding;
  logic [SW-1:0]   outstanding_next;
  logic [SW-1:0]   occupancy;
  logic            req_fire;
  logic            pop_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            halt_enter;
  logic            flush;

  // Every in-flight fetch is either waiting for its tag (live path) or marked
  // for dropping, so the outstanding count is derived rather than stored.
  assign outstanding = SW'(tag_count) + SW'(drop_cnt);

  // The credit check counts an entry leaving the buffer this cycle as free;
  // that keeps a 1-cycle memory streaming one instruction per cycle while
  // still never letting buffered + in-flight fetches exceed DEPTH.
  assign if_valid       = (buf_count != '0);
  assign pop_fire       = if_valid && if_ready && !redirect_valid;
  assign occupancy      = outstanding + SW'(buf_count) - SW'(pop_fire);
  assign imem_req_valid = (state == ST_RUN) && !redirect_valid && (occupancy < SW'(DEPTH));
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop         = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep         = imem_rsp_valid && (drop_cnt == '0);
  assign outstanding_next = outstanding + SW'(req_fire) - SW'(imem_rsp_valid);

`ifdef IFU_HALT_ON_SYSTEM_EN
  assign halt_enter = (state == ST_RUN) && pop_fire && is_system(buf_dout[31:0]);
`else
  assign halt_enter = 1'b0;
`endif

  assign flush = redirect_valid || halt_enter;

  // Outputs read zero whenever nothing is presented, so stale buffer storage
  // never leaks to decode.
  assign if_instr  = if_valid ? buf_dout[31:0] : 32'h0;
  assign if_opcode = if_instr[6:0];
  assign if_pc     = if_valid ? buf_dout[BW-1:32] : '0;

  ifu_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (req_fire),
    .din   (pc),
    .pop   (rsp_keep),
    .dout  (tag_dout),
    .count (tag_count)
  );

  ifu_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_buf_q (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (rsp_keep),
    .din   ({tag_dout, imem_rsp_data}),
    .pop   (pop_fire),
    .dout  (buf_dout),
    .count (buf_count)
  );

  // Fetch state machine with the PC and drop counter. On a flush every fetch
  // still in flight after this cycle's response is marked for dropping; the
  // response arriving in the flush cycle is already accounted for.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      halted   <= 1'b0;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_pc & ~XLEN'(3);
      end else if (req_fire) begin
        pc <= pc + XLEN'(4);
      end

      if (flush) begin
        drop_cnt <= CW'(outstanding_next);
      end else if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end

      if (redirect_valid) begin
        state  <= ST_RUN;
        halted <= 1'b0;
      end else begin
        case (state)
          ST_RESET: state <= ST_RUN;
          ST_RUN: begin
            if (halt_enter) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end
          ST_HALT:  state <= ST_HALT;
          default:  state <= ST_RESET;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Randomised and directed stimulus for instr_fetch_unit against a stream-level
// reference model: an in-order memory with per-request latency, and an
// expected PC sequence that restarts at each redirect target.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int              XLEN     = 64;
  localparam int              DEPTH    = 2;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0;

  logic            clk;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [6:0]      if_opcode;
  logic [XLEN-1:0] if_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halted;

  instr_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [63:0] sys_addr = 64'h1;
  logic [63:0] exp_pc;
  logic [63:0] next_req;
  int          live;
  logic        model_halted;
  logic        prev_redirect;
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  int          first_req_cyc;
  int          first_valid_cyc;
  int          pops = 0;
  logic        hit;

  // Memory image: a hash of the address, with the SYSTEM opcode avoided
  // except at the one address chosen by a directed test.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    if (a == sys_addr) return 32'h00000073;
    h = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
    if (h[6:0] == 7'b1110011) h[0] = 1'b0;
    return h;
  endfunction

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Hold reset for n cycles checking reset values, then release it.
  task automatic doReset(input int n);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_req_valid", imem_req_valid, 0);
      checkOutput("rst_imem_addr", imem_addr, RESET_PC);
      checkOutput("rst_if_valid", if_valid, 0);
      checkOutput("rst_if_instr", if_instr, 0);
      checkOutput("rst_if_opcode", if_opcode, 0);
      checkOutput("rst_if_pc", if_pc, 0);
      checkOutput("rst_halted", halted, 0);
    end
    mq_addr.delete();
    mq_due.delete();
    exp_pc = RESET_PC;
    next_req = RESET_PC;
    live = 0;
    model_halted = 1'b0;
    prev_redirect = 1'b0;
    first_req_cyc = -1;
    first_valid_cyc = -1;
    cyc = 0;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, let the DUT settle, compare against the
  // model and advance the model by whatever handshakes happen at the edge.
  task automatic applyStimulus(input logic redir, input logic [63:0] rpc, input logic ifr,
                               input logic reqr, input logic redir_on_rsp_pop);
    logic [31:0] word;
    logic        halting;
    int          d;
    halting = 1'b0;
    @(posedge clk); #1;
    cyc++;
    redirect_valid = redir;
    redirect_pc = rpc;
    if_ready = ifr;
    imem_req_ready = reqr;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
    #1;
    if (redir_on_rsp_pop && !redir && !model_halted && if_valid && ifr && imem_rsp_valid) begin
      redirect_valid = 1'b1;
      hit = 1'b1;
      #1;
    end
    checkOutput("halted", halted, model_halted);
    if (prev_redirect) checkOutput("if_valid_after_redirect", if_valid, 0);
    if (redirect_valid) begin
      checkOutput("req_valid_during_redirect", imem_req_valid, 0);
      exp_pc = rpc & ~64'h3;
      next_req = exp_pc;
      live = 0;
      model_halted = 1'b0;
    end else begin
      if (model_halted) begin
        checkOutput("req_valid_halted", imem_req_valid, 0);
        checkOutput("if_valid_halted", if_valid, 0);
      end
      if (imem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
      if (if_valid) begin
        word = mem_word(exp_pc);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        checkOutput("if_pc", if_pc, exp_pc);
        checkOutput("if_instr", if_instr, word);
        checkOutput("if_opcode", if_opcode, word[6:0]);
        if (ifr) begin
          pops++;
          live--;
          exp_pc = exp_pc + 64'd4;
`ifdef IFU_HALT_ON_SYSTEM_EN
          if (word[6:0] == 7'b1110011) halting = 1'b1;
`endif
        end
      end
      if (imem_req_valid && reqr) begin
        checkOutput("imem_addr", imem_addr, next_req);
        next_req = next_req + 64'd4;
        live++;
        checkOutput("credit_limit", live <= DEPTH, 1);
        d = cyc + mem_lat;
        if (mq_due.size() > 0 && mq_due[$] > d) d = mq_due[$];
        mq_addr.push_back(imem_addr);
        mq_due.push_back(d);
      end
      if (halting) begin
        model_halted = 1'b1;
        live = 0;
      end
    end
    if (imem_rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    prev_redirect = redirect_valid;
  endtask

  initial begin
    int valid_cycles;
    int p0;
    logic bounded;

    // Reset, then a 1-cycle memory with decode always ready.
    doReset(3);
    mem_lat = 1;
    valid_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (if_valid && cyc >= 3) valid_cycles++;
    end
    checkOutput("first_req_cycle", first_req_cyc, 1);
    checkOutput("first_valid_cycle", first_valid_cyc, 3);
    checkOutput("steady_throughput", valid_cycles, 10);

    // Decode stalls: the fetch window fills to DEPTH and stops.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("stall_fill", live, DEPTH);
    checkOutput("stall_no_req", imem_req_valid, 0);

    // Slow memory, redirect with two fetches in flight.
    mem_lat = 3;
    bounded = 1'b0;
    for (int i = 0; i < 30 && !bounded; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (mq_addr.size() == 2) bounded = 1'b1;
    end
    checkOutput("two_in_flight", bounded, 1);
    p0 = pops;
    applyStimulus(1'b1, 64'h103, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("redirect_progress", pops > p0, 1);

    // Redirect landing on a cycle with a response and a pop.
    mem_lat = 1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) applyStimulus(1'b0, 64'h200, 1'b1, 1'b1, 1'b1);
    checkOutput("redirect_rsp_pop_seen", hit, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("req_after_redirect", imem_req_valid, 1);
    checkOutput("addr_after_redirect", imem_addr, 64'h200);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // SYSTEM instruction at 0x8.
    sys_addr = 64'h8;
    p0 = pops;
    applyStimulus(1'b1, 64'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h40, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("system_phase_progress", pops > p0 + 3, 1);
    sys_addr = 64'h1;

    // Random traffic with occasional redirects, including near address wrap.
    p0 = pops;
    for (int i = 0; i < 600; i++) begin
      logic [63:0] tgt;
      mem_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else tgt = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 39) == 0, tgt, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    checkOutput("random_progress", pops > p0 + 80, 1);

    // Reset in the middle of a stream with two fetches outstanding.
    mem_lat = 3;
    bounded = 1'b0;
    for (int i = 0; i < 30 && !bounded; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (mq_addr.size() == 2) bounded = 1'b1;
    end
    checkOutput("two_in_flight_before_rst", bounded, 1);
    doReset(1);
    mem_lat = 1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("restart_first_req_cycle", first_req_cyc, 1);
    checkOutput("restart_first_valid_cycle", first_valid_cyc, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
